eth_tx_frame_arbiter: RTL and testbench
=======================================

Name: eth_tx_frame_arbiter

Overview:
- Shares the single byte-wide TX AXI-stream input of the 1G RGMII MAC between N_PORTS frame sources, for example a CPU DMA path and a locally generated control/pause frame path.
- Arbitration is frame-granular round-robin: once granted, a source owns the MAC until its tlast beat is accepted.
- Frames longer than MAX_FRAME_LEN are truncated and marked bad via tuser, so the MAC TX FIFO drops them. The rest of that oversized input frame is then drained.
- Sits in the logic_clk domain directly upstream of the MAC tx_axis port.

Parameters:
- N_PORTS, 2, number of requesting sources; legal range 2..8.
- MAX_FRAME_LEN, 1522, maximum number of beats forwarded per frame; legal range ≥ 2.

Ports:
- clk  input  1  logic clock (125 MHz), same clock as the MAC logic side.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata  input  8*N_PORTS  per-source data; port i occupies bits [8i+7:8i].
- s_axis_tvalid  input  N_PORTS  per-source valid.
- s_axis_tready  output  N_PORTS  per-source ready.
- s_axis_tlast  input  N_PORTS  per-source end of frame.
- s_axis_tuser  input  N_PORTS  per-source bad-frame flag.
- m_axis_tdata  output  8  to MAC tx_axis_tdata.
- m_axis_tvalid  output  1  to MAC tx_axis_tvalid.
- m_axis_tready  input  1  from MAC tx_axis_tready.
- m_axis_tlast  output  1  to MAC tx_axis_tlast.
- m_axis_tuser  output  1  to MAC tx_axis_tuser.
- grant  output  N_PORTS  one-hot current owner; all zero in IDLE.
- busy  output  1  high in PASS or DRAIN.
- trunc_pulse  output  1  single-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; grant=0; busy=0; trunc_pulse=0.
  - beat_cnt=0; last_grant=N_PORTS-1, so port 0 has first priority.
  - All s_axis_tready=0; m_axis_tvalid/tlast/tuser=0.
  - Reset mid-frame abandons the frame silently; no tlast is emitted.
- States: IDLE, PASS, DRAIN. The state, grant, beat_cnt and last_grant are registers. The datapath mux is combinational from the registered grant.
- IDLE:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - If any s_axis_tvalid is high, select the first requesting index searching last_grant+1, last_grant+2, … modulo N_PORTS.
  - Next cycle: grant=onehot(sel), state=PASS, beat_cnt=0.
  - Arbitration latency is exactly 1 cycle from IDLE to the first forwarded beat.
  - A requester's tvalid must stay high once asserted (AXI rule). A requester that drops tvalid before being granted is simply skipped.
- PASS, with owner g:
  - m_axis_tdata/tvalid/tlast/tuser follow s_axis_*[g] combinationally.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready=0.
  - Zero-latency pass-through with no buffering.
  - Each handshake (m_axis_tvalid & m_axis_tready) increments beat_cnt. beat_cnt width is $clog2(MAX_FRAME_LEN+1) and it never wraps.
  - Handshake with s_axis_tlast[g]=1: state=IDLE, grant=0, last_grant=g.
  - Handshake with beat_cnt==MAX_FRAME_LEN-1 and s_axis_tlast[g]=0 (truncation):
    - The output beat is forced to m_axis_tlast=1, m_axis_tuser=1.
    - trunc_pulse=1 for the following cycle; state=DRAIN.
  - When tlast=1 arrives exactly on beat MAX_FRAME_LEN, this is a normal completion. No truncation occurs and tuser passes through unchanged.
- DRAIN, with owner g:
  - m_axis_tvalid=0; s_axis_tready[g]=1; all others 0.
  - Beats are discarded.
  - On s_axis handshake with tlast[g]=1: state=IDLE, grant=0, last_grant=g.
- busy = (state!=IDLE). grant is stable for the whole PASS+DRAIN interval.
- A back-to-back frame from the same source costs one IDLE cycle. Round-robin guarantees any continuously requesting port is served within N_PORTS frames.
- Simultaneous requests in IDLE are resolved by the round-robin order only; there is no fixed priority.
- m_axis_tready low stalls PASS indefinitely. beat_cnt and state hold during the stall.

Test Plan:
- Single source: port 0 sends a 64-beat frame, data 0x00..0x3F, m_axis_tready=1 → grant=01 one cycle after tvalid; 64 output beats identical to input; tlast on beat 64; tuser=0; then IDLE with grant=00.
- Contention: ports 0 and 1 continuously valid with 10-beat frames → output frames alternate 0,1,0,1; exactly one IDLE cycle between frames; no beat interleaving between sources.
- Backpressure: port 1 sends a 20-beat frame while m_axis_tready toggles every cycle → all 20 bytes delivered in order; s_axis_tready[1] mirrors m_axis_tready; s_axis_tready[0]=0 throughout.
- Truncation with MAX_FRAME_LEN=16: port 0 sends a 40-beat frame →
  - 16 output beats, with beat 16 carrying tlast=1, tuser=1.
  - trunc_pulse high for 1 cycle.
  - The remaining 24 input beats are accepted with m_axis_tvalid=0.
  - Then IDLE.
- Boundary with MAX_FRAME_LEN=16: a frame of exactly 16 beats with input tuser=0 → output tlast on beat 16, tuser=0, trunc_pulse never asserted.
- Reset mid-frame: assert rst_n=0 at beat 5 of port 1's frame → grant, busy, m_axis_tvalid and s_axis_tready drop immediately (asynchronously). After release, port 0 and port 1 both requesting → port 0 is granted first.

Source files
------------

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the byte-wide MAC TX AXI-stream.
// A granted source owns the output until its tlast beat is accepted. Frames
// longer than MAX_FRAME_LEN are cut with tlast+tuser so the MAC drops them,
// and the remainder of the oversized input frame is drained.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; round-robin pick among requesters for next cycle
// ST_PASS  | owner's beats pass through combinationally, beats counted
// ST_DRAIN | frame was truncated; owner's remaining beats are discarded
module eth_tx_frame_arbiter #(
  parameter int N_PORTS       = 2,
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*N_PORTS-1:0]   s_axis_tdata,
  input  logic [N_PORTS-1:0]     s_axis_tvalid,
  output logic [N_PORTS-1:0]     s_axis_tready,
  input  logic [N_PORTS-1:0]     s_axis_tlast,
  input  logic [N_PORTS-1:0]     s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [N_PORTS-1:0]     grant,
  output logic                   busy,
  output logic                   trunc_pulse
);

  localparam int IW = $clog2(N_PORTS);
  localparam int CW = $clog2(MAX_FRAME_LEN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [IW-1:0]      LAST_RST  = IW'(N_PORTS - 1);
  localparam logic [CW-1:0]      CNT_TRUNC = CW'(MAX_FRAME_LEN - 1);
  localparam logic [CW-1:0]      CNT_MAX   = CW'(MAX_FRAME_LEN);
  localparam logic [N_PORTS-1:0] GRANT_ONE = {{(N_PORTS-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic               trunc_q, trunc_d;

  logic [IW-1:0]      sel_idx;
  logic               sel_found;
  int                 cand;

  logic               in_pass, in_drain;
  logic [7:0]         own_data;
  logic               own_valid, own_last, own_user;
  logic               out_hs, trunc_beat;

  // Owner's stream, selected from the registered owner index
  assign own_data  = s_axis_tdata[{owner_q, 3'b000} +: 8];
  assign own_valid = s_axis_tvalid[owner_q];
  assign own_last  = s_axis_tlast[owner_q];
  assign own_user  = s_axis_tuser[owner_q];

  assign in_pass    = (state_q == ST_PASS);
  assign in_drain   = (state_q == ST_DRAIN);
  assign out_hs     = in_pass & own_valid & m_axis_tready;
  // Beat MAX_FRAME_LEN without tlast is the cut point
  assign trunc_beat = in_pass & ~own_last & (beat_cnt_q == CNT_TRUNC);

  assign m_axis_tdata  = in_pass ? own_data : 8'h00;
  assign m_axis_tvalid = in_pass & own_valid;
  assign m_axis_tlast  = in_pass & (own_last | trunc_beat);
  assign m_axis_tuser  = in_pass & (own_user | trunc_beat);
  assign s_axis_tready = grant_q & {N_PORTS{(in_pass & m_axis_tready) | in_drain}};

  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign trunc_pulse = trunc_q;

  // Round-robin search starting just after the last served port
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = (int'(last_grant_q) + k) % N_PORTS;
      if (!sel_found && s_axis_tvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  // Next-state logic for ownership, beat counting and truncation
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    trunc_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d    = ST_PASS;
          grant_d    = GRANT_ONE << sel_idx;
          owner_d    = sel_idx;
          beat_cnt_d = '0;
        end
      end
      ST_PASS: begin
        if (out_hs) begin
          if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + CW'(1);
          if (own_last) begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            last_grant_d = owner_q;
          end else if (trunc_beat) begin
            state_d = ST_DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (own_valid && own_last) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          last_grant_d = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= LAST_RST;
      beat_cnt_q   <= '0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      trunc_q      <= trunc_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: randomized frame sources push
// expected output beats when each frame is issued; a monitor tracks frame
// ownership and pops/compares on every output handshake.
module tb_eth_tx_frame_arbiter;

  localparam int N    = 2;
  localparam int MAXL = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] s_axis_tdata;
  logic [N-1:0]   s_axis_tvalid;
  logic [N-1:0]   s_axis_tready;
  logic [N-1:0]   s_axis_tlast;
  logic [N-1:0]   s_axis_tuser;
  logic [7:0]     m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic [N-1:0]   grant;
  logic           busy;
  logic           trunc_pulse;

  always #4 clk = ~clk;

  eth_tx_frame_arbiter #(.N_PORTS(N), .MAX_FRAME_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .grant(grant), .busy(busy), .trunc_pulse(trunc_pulse)
  );

  beat_t in_q[N][$];
  beat_t exp_q[N][$];
  int    force_q[N][$];
  int    frames_left[N];
  int    tready_mode;
  int    bubble_pct;
  int    compared = 0;
  int    mismatched = 0;
  int    out_beats = 0;
  int    trunc_exp_cnt = 0;
  int    trunc_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Build one input frame and its expected output image
  task automatic gen_frame(input int p);
    int    len;
    logic  usr;
    int    nout;
    beat_t b;
    bit    forced;
    forced = (force_q[p].size() > 0);
    if (forced) begin
      len = force_q[p].pop_front();
      usr = 1'b0;
    end else begin
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 8);
        1:       len = MAXL - 1 + int'($urandom_range(0, 2));
        2:       len = $urandom_range(MAXL + 2, 40);
        default: len = $urandom_range(2, MAXL - 2);
      endcase
      usr = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < len; i++) begin
      b.d = forced ? 8'(i) : 8'($urandom);
      b.l = (i == len - 1);
      b.u = usr;
      in_q[p].push_back(b);
    end
    nout = (len > MAXL) ? MAXL : len;
    for (int i = 0; i < nout; i++) begin
      b = in_q[p][i];
      if (len > MAXL && i == nout - 1) begin
        b.l = 1'b1;
        b.u = 1'b1;
      end
      exp_q[p].push_back(b);
    end
    if (len > MAXL) trunc_exp_cnt++;
    frames_left[p]--;
  endtask

  // Source driver: updates inputs 1 time unit after each rising edge
  initial begin : driver
    logic [N-1:0] hs;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int p = 0; p < N; p++) begin
          in_q[p].delete();
          exp_q[p].delete();
        end
        s_axis_tvalid = '0;
      end else begin
        for (int p = 0; p < N; p++) begin
          if (hs[p] && in_q[p].size() > 0) void'(in_q[p].pop_front());
          if (in_q[p].size() == 0 && frames_left[p] > 0) gen_frame(p);
          if (s_axis_tvalid[p] && !hs[p]) begin
            s_axis_tvalid[p] = 1'b1;
          end else if (in_q[p].size() > 0 && int'($urandom_range(0, 99)) >= bubble_pct) begin
            s_axis_tvalid[p]         = 1'b1;
            s_axis_tdata[p*8 +: 8]   = in_q[p][0].d;
            s_axis_tlast[p]          = in_q[p][0].l;
            s_axis_tuser[p]          = in_q[p][0].u;
          end else begin
            s_axis_tvalid[p] = 1'b0;
          end
        end
        case (tready_mode)
          0:       m_axis_tready = 1'b1;
          1:       m_axis_tready = ~m_axis_tready;
          default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
  end

  // Monitor: ownership model plus scoreboard pop on each output handshake
  initial begin : monitor
    int    m_owner;
    int    m_last;
    int    m_cnt;
    bit    m_drain;
    bit    exp_tr;
    int    g;
    int    c;
    beat_t e;
    m_owner = -1; m_last = N - 1; m_cnt = 0; m_drain = 0; exp_tr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_owner = -1; m_last = N - 1; m_cnt = 0; m_drain = 0; exp_tr = 0;
      end else begin
        check("trunc_pulse", trunc_pulse, exp_tr);
        if (trunc_pulse) trunc_seen++;
        exp_tr = 0;
        if (m_owner < 0) begin
          check("idle_grant", grant, 0);
          check("idle_busy", busy, 0);
          check("idle_m_tvalid", m_axis_tvalid, 0);
          check("idle_s_tready", s_axis_tready, 0);
          if (|s_axis_tvalid) begin
            for (int k = 1; k <= N; k++) begin
              c = (m_last + k) % N;
              if (m_owner < 0 && s_axis_tvalid[c]) m_owner = c;
            end
            m_cnt = 0;
            m_drain = 0;
          end
        end else begin
          g = m_owner;
          check("own_grant", grant, 32'(1) << g);
          check("own_busy", busy, 1);
          if (m_drain) begin
            check("drain_m_tvalid", m_axis_tvalid, 0);
            check("drain_s_tready", s_axis_tready, 32'(1) << g);
            if (s_axis_tvalid[g] && s_axis_tlast[g]) begin
              m_owner = -1;
              m_last  = g;
            end
          end else begin
            check("pass_s_tready", s_axis_tready, m_axis_tready ? (32'(1) << g) : 0);
            check("pass_m_tvalid", m_axis_tvalid, s_axis_tvalid[g]);
            if (m_axis_tvalid && m_axis_tready) begin
              out_beats++;
              if (exp_q[g].size() == 0) begin
                check("exp_underflow", 1, 0);
              end else begin
                e = exp_q[g].pop_front();
                check("beat_data", m_axis_tdata, e.d);
                check("beat_last", m_axis_tlast, e.l);
                check("beat_user", m_axis_tuser, e.u);
              end
              m_cnt++;
              if (s_axis_tlast[g]) begin
                m_owner = -1;
                m_last  = g;
              end else if (m_cnt == MAXL) begin
                m_drain = 1;
                exp_tr  = 1;
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      done = !busy && (s_axis_tvalid == '0);
      for (int p = 0; p < N; p++)
        if (frames_left[p] != 0 || in_q[p].size() != 0) done = 0;
    end
    check({name, "_timeout"}, done, 1);
    for (int p = 0; p < N; p++) check({name, "_leftover"}, exp_q[p].size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int b0;
    rst_n = 1'b0;
    tready_mode = 0;
    bubble_pct = 0;
    for (int p = 0; p < N; p++) frames_left[p] = 0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_trunc", trunc_pulse, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tuser", m_axis_tuser, 0);
    check("rst_s_tready", s_axis_tready, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single source, including exact-boundary and oversized frames
    force_q[0].push_back(MAXL);
    force_q[0].push_back(40);
    force_q[0].push_back(MAXL + 1);
    force_q[0].push_back(64);
    frames_left[0] = 5;
    wait_done("single", 2000);

    // Continuous contention with 10-beat frames
    for (int i = 0; i < 6; i++) begin
      force_q[0].push_back(10);
      force_q[1].push_back(10);
    end
    frames_left[0] = 6;
    frames_left[1] = 6;
    wait_done("contention", 2000);

    // Toggling backpressure on a 20-beat frame from port 1
    tready_mode = 1;
    force_q[1].push_back(20);
    frames_left[1] = 1;
    wait_done("backpressure", 1000);

    // Random lengths, random backpressure and source bubbles
    tready_mode = 2;
    bubble_pct = 25;
    frames_left[0] = 12;
    frames_left[1] = 12;
    wait_done("random", 8000);

    // Reset in the middle of port 1's frame
    tready_mode = 0;
    bubble_pct = 0;
    force_q[1].push_back(10);
    frames_left[1] = 1;
    b0 = out_beats;
    n = 0;
    while (out_beats < b0 + 5 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midrst_reach_beat5", out_beats >= b0 + 5, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_s_tready", s_axis_tready, 0);
    frames_left[0] = 1;
    frames_left[1] = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("postrst_first_grant", grant, 1);
    wait_done("postrst", 1000);

    check("trunc_count", trunc_seen, trunc_exp_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
